// File: rtl/ifft_tile_arb_pkg.sv
// Shared constants, state encoding and width helper for the IFFT tile arbiter.
package ifft_tile_arb_pkg;

    localparam int unsigned FFT_ROWS_DEF = 8;
    localparam int unsigned FFT_CHNL_DEF = 8;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_ROWS = 2'd1;
    localparam state_t ST_GAP  = 2'd2;

    function automatic int unsigned cplx_w(input int unsigned datalen);
        return 2 * datalen;
    endfunction

endpackage

// File: rtl/ifft_tag_fifo.sv
// Small synchronous FIFO carrying requester IDs of tiles in flight through the IFFT.
module ifft_tag_fifo #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);

endmodule

// File: rtl/ifft_tile_arb.sv
// Round-robin tile arbiter feeding rows to a 2D IFFT and tagging tiles as they emerge.
module ifft_tile_arb
    import ifft_tile_arb_pkg::*;
#(
    parameter int unsigned DATALEN  = 16,
    parameter int unsigned FFTCHNL  = FFT_CHNL_DEF,
    parameter int unsigned NREQ     = 4,
    parameter int unsigned ROWS     = FFT_ROWS_DEF,
    parameter int unsigned GAP      = 8,
    parameter int unsigned OUTBEATS = 1,
    parameter int unsigned TAGDEPTH = 4
) (
    input  logic                                           clk,
    input  logic                                           rstn,
    input  logic [NREQ-1:0]                                req,
    input  logic [NREQ-1:0][FFTCHNL-1:0][cplx_w(DATALEN)-1:0] req_data,
    output logic [NREQ-1:0]                                grant,
    output logic [$clog2(ROWS)-1:0]                        rowidx,
    output logic                                           fft_invalid,
    output logic [FFTCHNL-1:0][cplx_w(DATALEN)-1:0]        fft_indata,
    input  logic                                           fft_outvalid,
    output logic [$clog2(NREQ)-1:0]                        out_tag,
    output logic                                           out_tagvalid,
    output logic                                           err_underflow
);

    localparam int unsigned CW       = cplx_w(DATALEN);
    localparam int unsigned RW       = $clog2(ROWS);
    localparam int unsigned IW       = $clog2(NREQ);
    localparam int unsigned GW       = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int unsigned BW       = (OUTBEATS > 1) ? $clog2(OUTBEATS) : 1;
    localparam int unsigned GAP_LAST = (GAP > 0) ? GAP - 1 : 0;

    state_t                         state_q, state_d;
    logic [NREQ-1:0]                grant_q, grant_d;
    logic [IW-1:0]                  owner_q, owner_d;
    logic [IW-1:0]                  rr_ptr_q, rr_ptr_d;
    logic [RW-1:0]                  rowidx_q, rowidx_d;
    logic [GW-1:0]                  gap_cnt_q, gap_cnt_d;
    logic [BW-1:0]                  beat_q, beat_d;
    logic                           fft_invalid_q, fft_invalid_d;
    logic [FFTCHNL-1:0][CW-1:0]     fft_indata_q, fft_indata_d;
    logic                           err_q, err_d;

    logic          win_found;
    logic [IW-1:0] win_idx;
    logic [IW-1:0] cand;
    logic          push, pop;
    logic          tag_full, tag_empty;

    // Scan from the highest offset down so the closest requester to rr_ptr wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            cand = IW'((int'(rr_ptr_q) + i) % int'(NREQ));
            if (req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        owner_d       = owner_q;
        rr_ptr_d      = rr_ptr_q;
        rowidx_d      = rowidx_q;
        gap_cnt_d     = gap_cnt_q;
        push          = 1'b0;
        fft_invalid_d = (state_q == ST_ROWS);
        fft_indata_d  = fft_invalid_d ? req_data[owner_q] : fft_indata_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found && !tag_full) begin
                    state_d  = ST_ROWS;
                    grant_d  = NREQ'(1) << win_idx;
                    owner_d  = win_idx;
                    rowidx_d = '0;
                    push     = 1'b1;
                    rr_ptr_d = (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + IW'(1);
                end
            end
            ST_ROWS: begin
                if (rowidx_q == RW'(ROWS - 1)) begin
                    grant_d  = '0;
                    rowidx_d = '0;
                    if (GAP > 0) begin
                        state_d   = ST_GAP;
                        gap_cnt_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    rowidx_d = rowidx_q + RW'(1);
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GW'(GAP_LAST)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output-side beat counting; a beat with nothing queued only flags the error.
    always_comb begin
        pop    = 1'b0;
        beat_d = beat_q;
        err_d  = err_q;
        if (fft_outvalid) begin
            if (tag_empty) begin
                err_d = 1'b1;
            end else if (beat_q == BW'(OUTBEATS - 1)) begin
                pop    = 1'b1;
                beat_d = '0;
            end else begin
                beat_d = beat_q + BW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            owner_q       <= '0;
            rr_ptr_q      <= '0;
            rowidx_q      <= '0;
            gap_cnt_q     <= '0;
            beat_q        <= '0;
            fft_invalid_q <= 1'b0;
            fft_indata_q  <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            owner_q       <= owner_d;
            rr_ptr_q      <= rr_ptr_d;
            rowidx_q      <= rowidx_d;
            gap_cnt_q     <= gap_cnt_d;
            beat_q        <= beat_d;
            fft_invalid_q <= fft_invalid_d;
            fft_indata_q  <= fft_indata_d;
            err_q         <= err_d;
        end
    end

    ifft_tag_fifo #(
        .WIDTH (IW),
        .DEPTH (TAGDEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (push),
        .push_data (win_idx),
        .pop       (pop),
        .head      (out_tag),
        .full      (tag_full),
        .empty     (tag_empty)
    );

    assign grant         = grant_q;
    assign rowidx        = rowidx_q;
    assign fft_invalid   = fft_invalid_q;
    assign fft_indata    = fft_indata_q;
    assign out_tagvalid  = fft_outvalid && !tag_empty;
    assign err_underflow = err_q;

endmodule

// File: tb/tb_ifft_tile_arb.sv
// Directed bench for ifft_tile_arb at default parameters (4 requesters, 8 rows, GAP 8, 4 tags).
module tb_ifft_tile_arb;

    logic                   clk = 1'b0;
    logic                   rstn;
    logic [3:0]             req;
    logic [3:0][7:0][31:0]  req_data;
    logic [3:0]             grant;
    logic [2:0]             rowidx;
    logic                   fft_invalid;
    logic [7:0][31:0]       fft_indata;
    logic                   fft_outvalid;
    logic [1:0]             out_tag;
    logic                   out_tagvalid;
    logic                   err_underflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ifft_tile_arb dut (
        .clk           (clk),
        .rstn          (rstn),
        .req           (req),
        .req_data      (req_data),
        .grant         (grant),
        .rowidx        (rowidx),
        .fft_invalid   (fft_invalid),
        .fft_indata    (fft_indata),
        .fft_outvalid  (fft_outvalid),
        .out_tag       (out_tag),
        .out_tagvalid  (out_tagvalid),
        .err_underflow (err_underflow)
    );

    // Every requester drives {id, channel, rowidx} for the row currently requested.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 8; j++) begin
                req_data[r][j] = {8'(r), 8'(j), 16'(rowidx)};
            end
        end
    end

    function automatic logic [255:0] exp_row(input int k, input int row);
        logic [255:0] v;
        for (int j = 0; j < 8; j++) begin
            v[j*32 +: 32] = {8'(k), 8'(j), 16'(row)};
        end
        return v;
    endfunction

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn         = 1'b0;
        req          = '0;
        fft_outvalid = 1'b0;
        repeat (2) step();
        rstn = 1'b1;
    endtask

    task automatic wait_grant(input int budget, output logic [3:0] g);
        int n;
        g = '0;
        n = 0;
        while (g == '0 && n < budget) begin
            step();
            g = grant;
            n++;
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (grant != '0 && n < budget) begin
            step();
            n++;
        end
        chk("idle_wait", 256'(grant == '0), 256'(1));
    endtask

    task automatic pulse_out(input string tag, input logic [1:0] exp_tag);
        fft_outvalid = 1'b1;
        #1;
        chk({tag, "_tagvalid"}, 256'(out_tagvalid), 256'(1));
        chk({tag, "_tag"}, 256'(out_tag), 256'(exp_tag));
        step();
        fft_outvalid = 1'b0;
    endtask

    initial begin
        logic [3:0] g;
        logic       exp_g;
        logic       exp_v;
        int         ntiles;
        logic       prev;

        // Reset values
        rstn         = 1'b0;
        req          = '0;
        fft_outvalid = 1'b0;
        #2;
        chk("rst_grant", 256'(grant), 256'(0));
        chk("rst_rowidx", 256'(rowidx), 256'(0));
        chk("rst_invalid", 256'(fft_invalid), 256'(0));
        chk("rst_indata", 256'(fft_indata), 256'(0));
        chk("rst_tag", 256'(out_tag), 256'(0));
        chk("rst_tagvalid", 256'(out_tagvalid), 256'(0));
        chk("rst_err", 256'(err_underflow), 256'(0));

        // Single requester: 8 row cycles, strobes one cycle later, gap, then regrant
        do_reset();
        req = 4'b0001;
        for (int k = 1; k <= 19; k++) begin
            step();
            exp_g = (k >= 1 && k <= 8) || (k >= 18);
            exp_v = (k >= 2 && k <= 9) || (k >= 19);
            chk($sformatf("a_grant_%0d", k), 256'(grant), exp_g ? 256'(4'b0001) : 256'(0));
            chk($sformatf("a_inv_%0d", k), 256'(fft_invalid), 256'(exp_v));
            if (k >= 1 && k <= 8) begin
                chk($sformatf("a_row_%0d", k), 256'(rowidx), 256'(k - 1));
            end
            if (k >= 2 && k <= 9) begin
                chk($sformatf("a_data_%0d", k), fft_indata, exp_row(0, k - 2));
            end
        end

        // All requesting: round-robin order, tags pop in grant order
        do_reset();
        req = 4'b1111;
        wait_grant(40, g);
        chk("rr_0", 256'(g), 256'(4'b0001));
        pulse_out("rr_pop0", 2'd0);
        wait_idle(20);
        wait_grant(40, g);
        chk("rr_1", 256'(g), 256'(4'b0010));
        step();
        chk("rr_1_data", fft_indata, exp_row(1, 0));
        wait_idle(20);
        wait_grant(40, g);
        chk("rr_2", 256'(g), 256'(4'b0100));
        wait_idle(20);
        wait_grant(40, g);
        chk("rr_3", 256'(g), 256'(4'b1000));
        wait_idle(20);
        wait_grant(40, g);
        chk("rr_4", 256'(g), 256'(4'b0001));
        pulse_out("rr_pop1", 2'd1);
        pulse_out("rr_pop2", 2'd2);

        // Tag FIFO full blocks the fifth tile until one beat drains it
        do_reset();
        req    = 4'b0001;
        ntiles = 0;
        prev   = 1'b0;
        for (int k = 0; k < 120; k++) begin
            step();
            if (grant != '0 && !prev) ntiles++;
            prev = (grant != '0);
        end
        chk("full_tiles", 256'(ntiles), 256'(4));
        pulse_out("full_pop", 2'd0);
        wait_grant(20, g);
        chk("full_regrant", 256'(g), 256'(4'b0001));

        // Output beat with nothing queued
        do_reset();
        fft_outvalid = 1'b1;
        #1;
        chk("uf_tagvalid", 256'(out_tagvalid), 256'(0));
        step();
        fft_outvalid = 1'b0;
        chk("uf_err", 256'(err_underflow), 256'(1));
        repeat (5) step();
        chk("uf_err_sticky", 256'(err_underflow), 256'(1));
        req = 4'b0100;
        wait_grant(40, g);
        chk("uf_grant", 256'(g), 256'(4'b0100));
        pulse_out("uf_pop", 2'd2);

        // Reset mid-tile aborts; priority returns to requester 0
        do_reset();
        req = 4'b0010;
        wait_grant(40, g);
        chk("ab_grant", 256'(g), 256'(4'b0010));
        repeat (3) step();
        chk("ab_row3", 256'(rowidx), 256'(3));
        rstn = 1'b0;
        #1;
        chk("ab_grant0", 256'(grant), 256'(0));
        chk("ab_row0", 256'(rowidx), 256'(0));
        chk("ab_inv0", 256'(fft_invalid), 256'(0));
        chk("ab_data0", fft_indata, 256'(0));
        req = 4'b1111;
        step();
        step();
        rstn = 1'b1;
        chk("ab_inv_hold", 256'(fft_invalid), 256'(0));
        wait_grant(40, g);
        chk("ab_regrant", 256'(g), 256'(4'b0001));
        chk("ab_regrant_row", 256'(rowidx), 256'(0));
        chk("ab_regrant_inv", 256'(fft_invalid), 256'(0));

        // Requests dropped before being granted are skipped
        req = 4'b0100;
        wait_idle(20);
        wait_grant(40, g);
        chk("drop_grant", 256'(g), 256'(4'b0100));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
